// File: rtl/alu_seq_unit.sv
// alu_seq_unit: decodes alu_op/func into a 3-bit ALU control code and executes it.
//   add/sub/and/or/xor, divide-by-zero and illegal ops finish one cycle after accept.
//   mul (shift-add) and div (restoring) iterate one bit per cycle.
// Optional macro: ALU_SIGNED_MULDIV_EN -- two's-complement mul/div. Operand magnitudes are
//   iterated and the sign is applied in one extra cycle.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; alu_op, func, a, b sampled on accept
//   out_valid/out_ready   result handshake; result, result_hi, alu_ctrl, zero and illegal
//                         are held while out_valid is high
//   busy                  unit is not idle
module alu_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       alu_ctrl,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] CtrlAdd = 3'b000;
  localparam logic [2:0] CtrlSub = 3'b001;
  localparam logic [2:0] CtrlMul = 3'b010;
  localparam logic [2:0] CtrlDiv = 3'b011;
  localparam logic [2:0] CtrlAnd = 3'b100;
  localparam logic [2:0] CtrlOr  = 3'b101;
  localparam logic [2:0] CtrlXor = 3'b110;
  localparam logic [2:0] CtrlIll = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StDone, StFix} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // hi/lo: mul = {partial product, remaining multiplier}; div = {remainder, dividend}
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             ill_q, ill_d;

  logic [2:0]       dec_ctrl;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] addend, step_hi, step_lo;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  always_comb begin
    dec_ctrl = CtrlIll;
    unique case (alu_op)
      2'b00: begin
        case (func)
          6'b100000: dec_ctrl = CtrlAdd;
          6'b100010: dec_ctrl = CtrlSub;
          6'b010010: dec_ctrl = CtrlMul;
          6'b011010: dec_ctrl = CtrlDiv;
          6'b101000: dec_ctrl = CtrlAnd;
          6'b100101: dec_ctrl = CtrlOr;
          6'b100110: dec_ctrl = CtrlXor;
          default:   dec_ctrl = CtrlIll;
        endcase
      end
      2'b01:   dec_ctrl = CtrlSub;
      2'b11:   dec_ctrl = CtrlAdd;
      default: dec_ctrl = CtrlIll;
    endcase
  end

`ifdef ALU_SIGNED_MULDIV_EN
  // neg_q: negate product (mul) or quotient (div); neg_rem_q: negate remainder
  logic             neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] prod_fix;
  assign mag_a    = a[WIDTH-1] ? -a : a;
  assign mag_b    = b[WIDTH-1] ? -b : b;
  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  // One iteration step for mul and div, selected by the latched control code
  always_comb begin
    addend   = lo_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, hi_q} + {1'b0, addend};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (ctrl_q == CtrlMul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
`ifdef ALU_SIGNED_MULDIV_EN
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          ctrl_d   = dec_ctrl;
          ill_d    = (dec_ctrl == CtrlIll);
          res_hi_d = '0;
          state_d  = StDone;
          unique case (dec_ctrl)
            CtrlAdd: res_d = a + b;
            CtrlSub: res_d = a - b;
            CtrlAnd: res_d = a & b;
            CtrlOr:  res_d = a | b;
            CtrlXor: res_d = a ^ b;
            CtrlMul, CtrlDiv: begin
              if (b == '0) begin
                // x*0 is trivially 0; x/0 returns all ones with a as remainder
                res_d    = (dec_ctrl == CtrlDiv) ? '1 : '0;
                res_hi_d = (dec_ctrl == CtrlDiv) ? a : '0;
              end else begin
                state_d = StExec;
                cnt_d   = CNT_W'(WIDTH);
                hi_d    = '0;
                lo_d    = (dec_ctrl == CtrlMul) ? mag_b : mag_a;
                opnd_d  = (dec_ctrl == CtrlMul) ? mag_a : mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
                neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem_d = a[WIDTH-1];
`endif
              end
            end
            default: res_d = '0;
          endcase
        end
      end
      StExec: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef ALU_SIGNED_MULDIV_EN
          state_d = StFix;
`else
          state_d  = StDone;
          res_d    = step_lo;
          res_hi_d = step_hi;
`endif
        end
      end
`ifdef ALU_SIGNED_MULDIV_EN
      StFix: begin
        state_d = StDone;
        if (ctrl_q == CtrlMul) begin
          res_d    = prod_fix[WIDTH-1:0];
          res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end else begin
          // -2^(W-1)/-1 needs no special case: the magnitude quotient negates to itself
          res_d    = neg_q ? -lo_q : lo_q;
          res_hi_d = neg_rem_q ? -hi_q : hi_q;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      ctrl_q   <= CtrlAdd;
      ill_q    <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      ctrl_q   <= ctrl_d;
      ill_q    <= ill_d;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = ill_q;
  assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit (WIDTH=32). Build with ALU_SIGNED_MULDIV_EN defined to
// exercise the signed mul/div variant.
module tb_alu_seq_unit;

  localparam int unsigned W = 32;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam int MdLat = W + 2;
`else
  localparam int MdLat = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic         out_valid, out_ready;
  logic [W-1:0] result, result_hi;
  logic [2:0]   alu_ctrl;
  logic         zero, illegal, busy;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .alu_ctrl  (alu_ctrl),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency to out_valid, check outputs, then consume.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] x, input logic [W-1:0] y, input int exp_lat,
                       input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                       input logic [2:0] exp_ctrl, input logic exp_ill);
    int lat;
    @(negedge clk);
    alu_op = op; func = fn; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;  // must not affect the latched operation
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},     64'(lat),       64'(exp_lat));
    chk({tag, "_res"},     64'(result),    64'(exp_res));
    chk({tag, "_hi"},      64'(result_hi), 64'(exp_hi));
    chk({tag, "_ctrl"},    64'(alu_ctrl),  64'(exp_ctrl));
    chk({tag, "_ill"},     64'(illegal),   64'(exp_ill));
    chk({tag, "_zero"},    64'(zero),      64'(exp_res == '0));
    chk({tag, "_inready"}, 64'(in_ready),  64'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; func = 6'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid",   64'(out_valid), 64'(0));
    chk("rst_busy",    64'(busy),      64'(0));
    chk("rst_inready", 64'(in_ready),  64'(1));
    chk("rst_res",     64'(result),    64'(0));
    chk("rst_hi",      64'(result_hi), 64'(0));
    chk("rst_ctrl",    64'(alu_ctrl),  64'(0));
    chk("rst_zero",    64'(zero),      64'(1));
    chk("rst_ill",     64'(illegal),   64'(0));

    // Single-cycle ops
    do_op("add",  2'b00, 6'b100000, 32'd5, 32'd7, 1, 32'd12, 32'd0, 3'b000, 1'b0);
    do_op("br",   2'b01, 6'b000000, 32'd9, 32'd9, 1, 32'd0,  32'd0, 3'b001, 1'b0);
    do_op("ldst", 2'b11, 6'b111111, 32'd3, 32'd4, 1, 32'd7,  32'd0, 3'b000, 1'b0);
    do_op("subr", 2'b00, 6'b100010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'd0, 3'b001, 1'b0);
    do_op("and",  2'b00, 6'b101000, 32'hF0F0, 32'hFF00, 1, 32'hF000, 32'd0, 3'b100, 1'b0);
    do_op("or",   2'b00, 6'b100101, 32'hF0F0, 32'hFF00, 1, 32'hFFF0, 32'd0, 3'b101, 1'b0);
    do_op("xor",  2'b00, 6'b100110, 32'hF0F0, 32'hFF00, 1, 32'h0FF0, 32'd0, 3'b110, 1'b0);

    // Iterative ops
`ifdef ALU_SIGNED_MULDIV_EN
    // -1 * 2 = -2
    do_op("mul", 2'b00, 6'b010010, 32'hFFFF_FFFF, 32'd2, MdLat, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
          3'b010, 1'b0);
    do_op("sdiv", 2'b00, 6'b011010, 32'hFFFF_FFF9, 32'd2, MdLat, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
          3'b011, 1'b0);
    do_op("smul", 2'b00, 6'b010010, 32'hFFFF_FFFD, 32'd4, MdLat, 32'hFFFF_FFF4, 32'hFFFF_FFFF,
          3'b010, 1'b0);
    do_op("sovf", 2'b00, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, MdLat, 32'h8000_0000, 32'd0,
          3'b011, 1'b0);
`else
    do_op("mul", 2'b00, 6'b010010, 32'hFFFF_FFFF, 32'd2, MdLat, 32'hFFFF_FFFE, 32'd1,
          3'b010, 1'b0);
    do_op("udiv", 2'b00, 6'b011010, 32'hFFFF_FFF9, 32'd2, MdLat, 32'h7FFF_FFFC, 32'd1,
          3'b011, 1'b0);
`endif
    do_op("div",  2'b00, 6'b011010, 32'd100, 32'd7, MdLat, 32'd14, 32'd2, 3'b011, 1'b0);
    do_op("mul0", 2'b00, 6'b010010, 32'd77, 32'd0, 1, 32'd0, 32'd0, 3'b010, 1'b0);
    do_op("div0", 2'b00, 6'b011010, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 32'd100, 3'b011, 1'b0);

    // Illegal ops
    do_op("ill_fn", 2'b00, 6'b111111, 32'd5, 32'd6, 1, 32'd0, 32'd0, 3'b111, 1'b1);
    do_op("ill_op", 2'b10, 6'b100000, 32'd5, 32'd6, 1, 32'd0, 32'd0, 3'b111, 1'b1);

    // Backpressure: result held while out_ready low, extra requests ignored
    @(negedge clk);
    alu_op = 2'b11; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      alu_op = 2'b01; a = 32'd50; b = 32'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_res",   64'(result),    64'(3));
      chk("bp_hold_ctrl",  64'(alu_ctrl),  64'(0));
      chk("bp_inready",    64'(in_ready),  64'(0));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_done_valid",   64'(out_valid), 64'(0));
    chk("bp_done_inready", 64'(in_ready),  64'(1));
    @(posedge clk); #1;
    chk("bp_noqueue", 64'(out_valid), 64'(0));

    // Put a nonzero result in place, then reset in the middle of a multiply
    do_op("pre_rst", 2'b00, 6'b100000, 32'd40, 32'd2, 1, 32'd42, 32'd0, 3'b000, 1'b0);
    @(negedge clk);
    alu_op = 2'b00; func = 6'b010010; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'(1));
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(busy),   64'(0));
    chk("arst_res",   64'(result), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_valid",   64'(out_valid), 64'(0));
    chk("mrst_busy",    64'(busy),      64'(0));
    chk("mrst_inready", 64'(in_ready),  64'(1));
    chk("mrst_res",     64'(result),    64'(0));
    chk("mrst_zero",    64'(zero),      64'(1));
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_discard", 64'(out_valid), 64'(0));
    do_op("post_rst", 2'b00, 6'b100000, 32'd5, 32'd7, 1, 32'd12, 32'd0, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
